// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD counters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

  // Bit offsets of each digit inside disp_bcd (mm:ss.cc, min tens at the top).
  localparam int CS_U_OFS  = 0;
  localparam int CS_T_OFS  = 4;
  localparam int SEC_U_OFS = 8;
  localparam int SEC_T_OFS = 12;
  localparam int MIN_U_OFS = 16;
  localparam int MIN_T_OFS = 20;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MAX; exposes its next value so the
// parent can register a display copy in the same cycle as the count.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   clr,
  input  logic                   en,
  output logic [2*DIGIT_W-1:0]   q_next,
  output logic                   carry
);

  localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
  localparam logic [DIGIT_W-1:0] MAX_U = DIGIT_W'(MAX % 10);

  logic [DIGIT_W-1:0] tens_reg, units_reg;
  logic [DIGIT_W-1:0] tens_next, units_next;
  logic               at_max;

  assign at_max = (tens_reg == MAX_T) && (units_reg == MAX_U);
  assign carry  = en && !clr && at_max;
  assign q_next = {tens_next, units_next};

  always_comb begin
    tens_next  = tens_reg;
    units_next = units_reg;
    if (clr) begin
      tens_next  = '0;
      units_next = '0;
    end else if (en) begin
      if (at_max) begin
        tens_next  = '0;
        units_next = '0;
      end else if (units_reg == DIGIT_W'(9)) begin
        units_next = '0;
        tens_next  = tens_reg + DIGIT_W'(1);
      end else begin
        units_next = units_reg + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tens_reg  <= '0;
      units_reg <= '0;
    end else begin
      tens_reg  <= tens_next;
      units_reg <= units_next;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear stopwatch controller with BCD mm:ss.cc count.
// Define STOPWATCH_LAP_EN to build the LAP state and lap snapshot register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        start_key,
  input  logic        lap_key,
  input  logic        clear_key,
  input  logic        tick_10ms,
  output logic        work,
  output logic        div_rst_n,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active
);

  state_t state_reg, state_next;
  logic   tick_q_reg;
  logic   tick_rise, count_en;
  logic   cs_carry, sec_carry, min_carry_unused;
  logic   counting_next;
  logic [2*DIGIT_W-1:0] cs_next, sec_next, min_next;
  logic [23:0] live_next, disp_next;
  logic        work_reg, div_rst_n_reg, running_reg;
  logic [23:0] disp_reg;

  assign tick_rise = tick_10ms && !tick_q_reg;
  // Ticks are only counted in the counting states; a clear discards them.
  assign count_en  = tick_rise && (state_reg == RUN || state_reg == LAP) && !clear_key;

  bcd_mod_counter #(.MAX(CS_MAX)) u_cs (
    .clk(clk_50), .srst(reset), .clr(clear_key), .en(count_en),
    .q_next(cs_next), .carry(cs_carry)
  );
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk_50), .srst(reset), .clr(clear_key), .en(cs_carry),
    .q_next(sec_next), .carry(sec_carry)
  );
  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk(clk_50), .srst(reset), .clr(clear_key), .en(sec_carry),
    .q_next(min_next), .carry(min_carry_unused)
  );

  always_comb begin
    live_next = '0;
    live_next[CS_U_OFS  +: DIGIT_W] = cs_next[DIGIT_W-1:0];
    live_next[CS_T_OFS  +: DIGIT_W] = cs_next[2*DIGIT_W-1:DIGIT_W];
    live_next[SEC_U_OFS +: DIGIT_W] = sec_next[DIGIT_W-1:0];
    live_next[SEC_T_OFS +: DIGIT_W] = sec_next[2*DIGIT_W-1:DIGIT_W];
    live_next[MIN_U_OFS +: DIGIT_W] = min_next[DIGIT_W-1:0];
    live_next[MIN_T_OFS +: DIGIT_W] = min_next[2*DIGIT_W-1:DIGIT_W];
  end

  always_comb begin
    state_next = state_reg;
    if (clear_key) begin
      state_next = IDLE;
    end else if (start_key) begin
      case (state_reg)
        IDLE, PAUSE: state_next = RUN;
        default:     state_next = PAUSE;
      endcase
    end else if (lap_key) begin
`ifdef STOPWATCH_LAP_EN
      case (state_reg)
        RUN:     state_next = LAP;
        LAP:     state_next = RUN;
        default: state_next = state_reg;
      endcase
`endif
    end
  end

  assign counting_next = (state_next == RUN) || (state_next == LAP);

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_reg, lap_next;
  logic        lap_active_reg;

  // Snapshot takes the post-increment count so it matches the live value at capture.
  always_comb begin
    lap_next = lap_reg;
    if (clear_key)
      lap_next = '0;
    else if (state_reg == RUN && state_next == LAP)
      lap_next = live_next;
  end

  assign disp_next = (state_next == LAP) ? lap_next : live_next;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      lap_reg        <= '0;
      lap_active_reg <= 1'b0;
    end else begin
      lap_reg        <= lap_next;
      lap_active_reg <= (state_next == LAP);
    end
  end

  assign lap_active = lap_active_reg;
`else
  logic lap_key_unused;
  assign lap_key_unused = lap_key;
  assign disp_next      = live_next;
  assign lap_active     = 1'b0;
`endif

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      tick_q_reg    <= 1'b1;
      work_reg      <= 1'b0;
      running_reg   <= 1'b0;
      div_rst_n_reg <= 1'b0;
      disp_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      // Divider output is high right after its clear; preloading 1 hides that edge.
      tick_q_reg    <= clear_key ? 1'b1 : tick_10ms;
      work_reg      <= counting_next;
      running_reg   <= counting_next;
      div_rst_n_reg <= !clear_key;
      disp_reg      <= disp_next;
    end
  end

  assign work      = work_reg;
  assign running   = running_reg;
  assign div_rst_n = div_rst_n_reg;
  assign disp_bcd  = disp_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed steps plus random keys/ticks
// against a model that tracks elapsed time as a plain centisecond integer.
module tb_stopwatch_ctrl;

  localparam int MAXM   = 1;
  localparam int PERIOD = (MAXM + 1) * 6000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk_50 = 1'b0;
  logic        reset, start_key, lap_key, clear_key, tick_10ms;
  logic        work, div_rst_n, running, lap_active;
  logic [23:0] disp_bcd;

  int total = 0;
  int bad   = 0;

  // Model state: elapsed centiseconds, snapshot, counting/frozen flags.
  int m_total, m_snap;
  bit m_count, m_frozen, m_divrst, m_tickq;

  stopwatch_ctrl #(.MAX_MIN(MAXM)) dut (
    .clk_50(clk_50), .reset(reset), .start_key(start_key), .lap_key(lap_key),
    .clear_key(clear_key), .tick_10ms(tick_10ms), .work(work),
    .div_rst_n(div_rst_n), .disp_bcd(disp_bcd), .running(running),
    .lap_active(lap_active)
  );

  always #10 clk_50 = ~clk_50;

  function automatic logic [23:0] to_bcd(input int t);
    int mn, s, c;
    mn = t / 6000;
    s  = (t / 100) % 60;
    c  = t % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input bit s, input bit l, input bit t);
    if (r) begin
      m_total = 0; m_snap = 0; m_count = 0; m_frozen = 0; m_divrst = 0; m_tickq = 1;
    end else if (c) begin
      m_total = 0; m_snap = 0; m_count = 0; m_frozen = 0; m_divrst = 0; m_tickq = 1;
    end else begin
      if (t && !m_tickq && m_count) m_total = (m_total + 1) % PERIOD;
      if (s) begin
        m_count  = !m_count;
        m_frozen = 0;
      end else if (l && LAP_EN && m_count) begin
        if (m_frozen) m_frozen = 0;
        else begin
          m_frozen = 1;
          m_snap   = m_total;
        end
      end
      m_divrst = 1;
      m_tickq  = t;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit l, input bit t);
    reset = r; clear_key = c; start_key = s; lap_key = l; tick_10ms = t;
    model_update(r, c, s, l, t);
    @(posedge clk_50);
    #1;
    check("work", 24'(work), 24'(m_count));
    check("running", 24'(running), 24'(m_count));
    check("lap_active", 24'(lap_active), 24'(m_frozen));
    check("div_rst_n", 24'(div_rst_n), 24'(m_divrst));
    check("disp_bcd", disp_bcd, m_frozen ? to_bcd(m_snap) : to_bcd(m_total));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic press(input bit c, input bit s, input bit l);
    step(0, c, s, l, 0);
  endtask

  initial begin
    bit t_lvl;
    bit rr, cc, ss, ll;
    reset = 1; clear_key = 0; start_key = 0; lap_key = 0; tick_10ms = 0;
    m_total = 0; m_snap = 0; m_count = 0; m_frozen = 0; m_divrst = 0; m_tickq = 1;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("rst_divrst_low", 24'(div_rst_n), 24'd0);
    check("rst_disp_zero", disp_bcd, 24'h000000);
    step(0, 0, 0, 0, 0);
    check("rel_divrst_high", 24'(div_rst_n), 24'd1);
    $display("reset: disp=%h work=%0d div_rst_n=%0d", disp_bcd, work, div_rst_n);

    // Run for 150 ticks.
    press(0, 1, 0);
    ticks(150);
    check("run_150", disp_bcd, 24'h000150);
    check("run_work", 24'(work), 24'd1);
    $display("run: disp=%h work=%0d running=%0d", disp_bcd, work, running);

    // Pause ignores ticks, resume continues from the held value.
    press(0, 1, 0);
    check("pause_work", 24'(work), 24'd0);
    ticks(5);
    check("pause_hold", disp_bcd, 24'h000150);
    press(0, 1, 0);
    ticks(3);
    check("resume", disp_bcd, 24'h000153);
    $display("pause/resume: disp=%h", disp_bcd);

    // Clear, start and a tick edge together while running.
    step(0, 1, 1, 0, 1);
    check("prio_divrst_low", 24'(div_rst_n), 24'd0);
    check("prio_disp", disp_bcd, 24'h000000);
    step(0, 0, 0, 0, 1);
    check("prio_divrst_high", 24'(div_rst_n), 24'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("prio_no_incr", disp_bcd, 24'h000000);
    check("prio_idle", 24'(running), 24'd0);
    $display("priority: disp=%h running=%0d", disp_bcd, running);

    // Carry chain and full wrap with MAX_MIN=1.
    press(0, 1, 0);
    ticks(99);
    check("wrap_099", disp_bcd, 24'h000099);
    ticks(1);
    check("wrap_100", disp_bcd, 24'h000100);
    ticks(11899);
    check("wrap_15999", disp_bcd, 24'h015999);
    ticks(1);
    check("wrap_zero", disp_bcd, 24'h000000);
    $display("wrap: disp=%h", disp_bcd);
    press(1, 0, 0);

    // Lap freeze and release.
    press(0, 1, 0);
    ticks(200);
    press(0, 0, 1);
    check("lap_active", 24'(lap_active), 24'(LAP_EN));
    ticks(30);
    check("lap_frozen", disp_bcd, LAP_EN ? 24'h000200 : 24'h000230);
    press(0, 0, 1);
    check("lap_release", disp_bcd, 24'h000230);
    check("lap_inactive", 24'(lap_active), 24'd0);
    $display("lap: disp=%h lap_active=%0d", disp_bcd, lap_active);

    // Random keys, ticks and occasional reset against the model.
    t_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom % 500) == 0;
      cc = ($urandom % 97) == 0;
      ss = ($urandom % 23) == 0;
      ll = ($urandom % 17) == 0;
      if (($urandom % 3) == 0) t_lvl = !t_lvl;
      step(rr, cc, ss, ll, t_lvl);
    end
    $display("random: disp=%h state run=%0d lap=%0d", disp_bcd, running, lap_active);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
